// File: rtl/i2s_frame_timer_v_if.sv
// Purpose : bundle of the frame timer's run request and timing outputs.
// Latency : none (wires only).
// Backpressure: none; the timer free-runs and consumers just observe the strobes.
// Signals : en_i (run request into the timer), bclk_o/lrclk_o (i2s clocks),
//           sampstart_o/valid_o (one-clk strobes), running_o, frame_cnt_o.
interface i2s_frame_timer_v_if #(
    parameter int FCNT_W = 16
);
    logic              en_i;
    logic              bclk_o;
    logic              lrclk_o;
    logic              sampstart_o;
    logic              valid_o;
    logic              running_o;
    logic [FCNT_W-1:0] frame_cnt_o;

    // master = the timer itself, slave = the i2s rx/tx and DSP side
    modport master (
        input  en_i,
        output bclk_o, lrclk_o, sampstart_o, valid_o, running_o, frame_cnt_o
    );

    modport slave (
        output en_i,
        input  bclk_o, lrclk_o, sampstart_o, valid_o, running_o, frame_cnt_o
    );
endinterface

// File: rtl/i2s_frame_timer_v.sv
// Purpose : i2s master timing - bclk, lrclk, frame sampstart and rx-valid strobes.
// Latency : all outputs registered; sampstart 1 clk after en_i seen, valid 1 clk after a wrap sampstart.
// Backpressure: none; en_i low lets the current 64-bclk frame finish, then idles.
// Ports   : clk_i, rst_i (async, active-high), bus (master modport): en_i in;
//           bclk_o, lrclk_o, sampstart_o, valid_o, running_o, frame_cnt_o out.
module i2s_frame_timer_v #(
    parameter int BCLK_HALF = 8,
    parameter int FCNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    i2s_frame_timer_v_if.master   bus
);

    localparam int               DIV_W    = $clog2(BCLK_HALF);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              sampstart_q, sampstart_d;
    logic              valid_q, valid_d;
    logic              running_q, running_d;
    logic              pend_q, pend_d;      // a frame wrapped last clock
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sampstart_q <= 1'b0;
            valid_q     <= 1'b0;
            running_q   <= 1'b0;
            pend_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sampstart_q <= sampstart_d;
            valid_q     <= valid_d;
            running_q   <= running_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        frame_cnt_d = frame_cnt_q;
        sampstart_d = 1'b0;
        pend_d      = 1'b0;
        // valid trails a wrap by one clock; the start strobe never sets pend,
        // so leaving IDLE never produces a valid.
        valid_d     = pend_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                bclk_d    = 1'b0;
                lrclk_d   = 1'b0;
                if (bus.en_i) begin
                    state_d     = ST_RUN;
                    sampstart_d = 1'b1;
                end
            end

            ST_RUN, ST_STOP: begin
                if (state_q == ST_RUN && !bus.en_i) begin
                    state_d = ST_STOP;
                end
                if (state_q == ST_STOP && bus.en_i) begin
                    state_d = ST_RUN;
                end

                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bclk_d    = ~bclk_q;
                    // falling bclk: advance bit position; lrclk only moves here
                    if (bclk_q) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        lrclk_d   = bit_cnt_d[5];
                        if (bit_cnt_q == 6'd63) begin
                            sampstart_d = 1'b1;
                            pend_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                            // stop only lands on a frame boundary; en_i seen
                            // here keeps the timer running without a gap
                            if (state_q == ST_STOP && !bus.en_i) begin
                                state_d = ST_IDLE;
                                bclk_d  = 1'b0;
                                lrclk_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d != ST_IDLE);
    end

    assign bus.bclk_o      = bclk_q;
    assign bus.lrclk_o     = lrclk_q;
    assign bus.sampstart_o = sampstart_q;
    assign bus.valid_o     = valid_q;
    assign bus.running_o   = running_q;
    assign bus.frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_i2s_frame_timer_v.sv
// Purpose : self-checking bench for i2s_frame_timer_v (two parameterisations).
// Latency : expected event times are written relative to the sampstart cycle t0.
// Backpressure: n/a; every wait is a fixed cycle budget.
module tb_i2s_frame_timer_v;

    localparam int BIG = 32'h7fff_ffff;
    localparam int K_SS = 0, K_VL = 1, K_BR = 2, K_BF = 3, K_LR = 4, K_RN = 5;

    typedef struct {
        int cyc;
        int dat;
    } ev_t;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   cyc  = 0;

    int n_pass  = 0;
    int n_total = 0;

    ev_t   q [2][6][$];
    string kname [6] = '{"sampstart", "valid", "bclk_rise", "bclk_fall", "lrclk", "running"};
    logic  pbc [2] = '{1'b0, 1'b0};
    logic  plr [2] = '{1'b0, 1'b0};
    logic  prn [2] = '{1'b0, 1'b0};
    int    last_rise [2] = '{-1000, -1000};
    int    last_ss   [2] = '{-1000, -1000};
    int    t0, t1;

    i2s_frame_timer_v_if #(.FCNT_W(16)) bus0 ();
    i2s_frame_timer_v_if #(.FCNT_W(4))  bus1 ();

    i2s_frame_timer_v #(.BCLK_HALF(4), .FCNT_W(16)) dut0 (
        .clk_i (clk),
        .rst_i (rst0),
        .bus   (bus0)
    );

    i2s_frame_timer_v #(.BCLK_HALF(2), .FCNT_W(4)) dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int d, input int k, input int c, input int v, input int lim);
        ev_t e;
        if (c < lim) begin
            e.cyc = c;
            e.dat = v;
            q[d][k].push_back(e);
        end
    endtask

    // Expected events for nfr back-to-back frames whose first sampstart is at t.
    task automatic exp_run(input int d, input int t, input int nfr, input int fc0,
                           input bit end_idle, input int lim);
        int b    = (d == 0) ? 4 : 2;
        int fp   = 128 * b;
        int msk  = (d == 0) ? 65535 : 15;
        int base;
        push(d, K_SS, t, fc0, lim);
        push(d, K_RN, t, 1, lim);
        for (int f = 0; f < nfr; f++) begin
            base = t + f * fp;
            for (int k = 0; k < 64; k++) begin
                push(d, K_BR, base + b + 2 * k * b, 0, lim);
                push(d, K_BF, base + 2 * (k + 1) * b, 0, lim);
            end
            push(d, K_LR, base + 64 * b, 1, lim);
            push(d, K_LR, base + fp, 0, lim);
            push(d, K_SS, base + fp, (fc0 + f + 1) & msk, lim);
            push(d, K_VL, base + fp + 1, 0, lim);
        end
        if (end_idle) push(d, K_RN, t + nfr * fp, 0, lim);
    endtask

    task automatic ev(input int d, input int k, input int v);
        ev_t e;
        n_total++;
        if (q[d][k].size() == 0) begin
            $display("FAIL unexpected_%s dut%0d: got event at cycle %0d, required none",
                     kname[k], d, cyc);
        end else begin
            e = q[d][k].pop_front();
            if (e.cyc == cyc && e.dat == v) n_pass++;
            else $display("FAIL %s dut%0d: got cycle %0d value %0d, required cycle %0d value %0d",
                          kname[k], d, cyc, v, e.cyc, e.dat);
        end
    endtask

    task automatic mon_one(input int d, input logic ss, input logic vl, input logic bc,
                           input logic lr, input logic rn, input int fc);
        if (ss) begin
            ev(d, K_SS, fc);
            chk("sampstart_clear_of_rise", (cyc - last_rise[d] >= 2) ? 1 : 0, 1);
            last_ss[d] = cyc;
        end
        if (vl) ev(d, K_VL, 0);
        if (bc && !pbc[d]) begin
            ev(d, K_BR, 0);
            chk("rise_clear_of_sampstart", (cyc - last_ss[d] >= 2) ? 1 : 0, 1);
            last_rise[d] = cyc;
        end
        if (!bc && pbc[d]) ev(d, K_BF, 0);
        if (lr != plr[d]) ev(d, K_LR, int'(lr));
        if (rn != prn[d]) ev(d, K_RN, int'(rn));
        pbc[d] = bc;
        plr[d] = lr;
        prn[d] = rn;
    endtask

    // Monitor: samples away from the active edge and pops the scoreboard.
    always @(negedge clk) begin
        mon_one(0, bus0.sampstart_o, bus0.valid_o, bus0.bclk_o, bus0.lrclk_o,
                bus0.running_o, int'(bus0.frame_cnt_o));
        mon_one(1, bus1.sampstart_o, bus1.valid_o, bus1.bclk_o, bus1.lrclk_o,
                bus1.running_o, int'(bus1.frame_cnt_o));
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int d);
        for (int k = 0; k < 6; k++) chk($sformatf("missing_%s_dut%0d", kname[k], d), q[d][k].size(), 0);
    endtask

    task automatic reset0();
        @(negedge clk);
        bus0.en_i = 1'b0;
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
    endtask

    task automatic start0(output int t);
        @(negedge clk);
        bus0.en_i = 1'b1;
        t = cyc + 1;
    endtask

    task automatic chk_quiet0(input string name);
        chk({name, "_bclk"}, int'(bus0.bclk_o), 0);
        chk({name, "_lrclk"}, int'(bus0.lrclk_o), 0);
        chk({name, "_running"}, int'(bus0.running_o), 0);
        chk({name, "_sampstart"}, int'(bus0.sampstart_o), 0);
        chk({name, "_valid"}, int'(bus0.valid_o), 0);
    endtask

    initial begin
        bus0.en_i = 1'b0;
        bus1.en_i = 1'b0;
        @(negedge clk);
        chk_quiet0("reset0");
        chk("reset0_fcnt", int'(bus0.frame_cnt_o), 0);
        chk("reset1_bclk", int'(bus1.bclk_o), 0);
        chk("reset1_running", int'(bus1.running_o), 0);
        chk("reset1_fcnt", int'(bus1.frame_cnt_o), 0);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        fork
            begin
                // two frames, en dropped mid second frame
                start0(t0);
                exp_run(0, t0, 2, 0, 1'b1, BIG);
                wait_cyc(t0 + 599);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 1024 + 10);
                chk("run2_fcnt", int'(bus0.frame_cnt_o), 2);
                drain(0);

                // en dropped early: frame still completes, then quiet
                reset0();
                start0(t0);
                exp_run(0, t0, 1, 0, 1'b1, BIG);
                wait_cyc(t0 + 98);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 512 + 20);
                chk_quiet0("stop_idle");
                drain(0);

                // drop then re-raise before the wrap: continuous through 3 frames
                reset0();
                start0(t0);
                exp_run(0, t0, 3, 0, 1'b1, BIG);
                wait_cyc(t0 + 98);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 298);
                bus0.en_i = 1'b1;
                wait_cyc(t0 + 1100);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 1536 + 10);
                drain(0);

                // async reset while bclk is high
                reset0();
                start0(t0);
                exp_run(0, t0, 1, 0, 1'b0, t0 + 200);
                push(0, K_BF, t0 + 200, 0, BIG);
                push(0, K_RN, t0 + 200, 0, BIG);
                wait_cyc(t0 + 199);
                chk("pre_reset_bclk", int'(bus0.bclk_o), 1);
                #1 rst0 = 1'b1;
                bus0.en_i = 1'b0;
                #1 chk_quiet0("async_reset");
                repeat (3) @(negedge clk);
                rst0 = 1'b0;
                start0(t0);
                exp_run(0, t0, 1, 0, 1'b1, BIG);
                wait_cyc(t0 + 98);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 512 + 10);
                drain(0);

                // en re-raised exactly on the wrap while stopping
                reset0();
                start0(t0);
                exp_run(0, t0, 2, 0, 1'b1, BIG);
                wait_cyc(t0 + 98);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 511);
                bus0.en_i = 1'b1;
                wait_cyc(t0 + 700);
                bus0.en_i = 1'b0;
                wait_cyc(t0 + 1024 + 10);
                drain(0);
            end
            begin
                // BCLK_HALF=2, 4-bit frame counter: 17 frames, counter wraps 15 -> 0
                @(negedge clk);
                bus1.en_i = 1'b1;
                t1 = cyc + 1;
                exp_run(1, t1, 17, 0, 1'b1, BIG);
                wait_cyc(t1 + 16 * 256 + 50);
                bus1.en_i = 1'b0;
                wait_cyc(t1 + 17 * 256 + 10);
                chk("dut1_fcnt_final", int'(bus1.frame_cnt_o), 1);
                drain(1);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
